systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder_if.sv | 29 ++
 rtl/systolic_feeder.sv | 118 +++++++++++
 tb/tb_systolic_feeder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
// Handshake and data bundle between a slice source and the systolic feeder.
// The master drives start/k_len and the slice stream; the slave produces the skewed edge lanes.
interface systolic_feeder_if #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int KW    = 8
);
    logic               start;
    logic [KW-1:0]      k_len;
    logic               s_valid;
    logic               s_ready;
    logic [N*WIDTH-1:0] a_vec;
    logic [N*WIDTH-1:0] b_vec;
    logic [N*WIDTH-1:0] west_out;
    logic [N*WIDTH-1:0] north_out;
    logic               clr_n;
    logic               busy;
    logic               done;

    modport master (
        output start, k_len, s_valid, a_vec, b_vec,
        input  s_ready, west_out, north_out, clr_n, busy, done
    );

    modport slave (
        input  start, k_len, s_valid, a_vec, b_vec,
        output s_ready, west_out, north_out, clr_n, busy, done
    );
endinterface

// File: rtl/systolic_feeder.sv
// Feeds one A column and one B row per accepted beat into an NxN systolic array,
// skewing lane i by i+1 registers, then flushes the array and pulses done.
module systolic_feeder_lane #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) sr_q[s] <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int s = 1; s < DEPTH; s++) sr_q[s] <= sr_q[s-1];
        end
    end

    assign q_o = sr_q[DEPTH-1];
endmodule

module systolic_feeder #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    parameter int KW    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    systolic_feeder_if.slave   bus
);
    localparam int FW = (2*N > 1) ? $clog2(2*N) : 1;
    // Flush ends once the last slice has crossed both skews of the array.
    localparam logic [FW-1:0] FLUSH_LAST = FW'(2*N-2);

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] beat_q, beat_d, klen_q, klen_d;
    logic [FW-1:0] flush_q, flush_d;
    logic          clr_n_q, clr_n_d;
    logic [KW-1:0] beat_inc;
    logic          accept;

    logic [N-1:0][WIDTH-1:0] a_in, b_in, west, north;

    assign bus.s_ready = (state_q == FEED);
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.clr_n   = clr_n_q;
    assign accept      = bus.s_ready && bus.s_valid;
    assign beat_inc    = beat_q + KW'(1);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        flush_d = flush_q;
        klen_d  = klen_q;
        clr_n_d = 1'b1;
        unique case (state_q)
            IDLE: if (bus.start) begin
                klen_d  = bus.k_len;
                beat_d  = '0;
                flush_d = '0;
                clr_n_d = 1'b0;
                state_d = (bus.k_len == '0) ? FLUSH : FEED;
            end
            FEED: if (accept) begin
                beat_d = beat_inc;
                if (beat_inc == klen_q) begin
                    state_d = FLUSH;
                    flush_d = '0;
                end
            end
            FLUSH: begin
                if (flush_q == FLUSH_LAST) state_d = DONE;
                else                       flush_d = flush_q + FW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            flush_q <= '0;
            klen_q  <= '0;
            clr_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            klen_q  <= klen_d;
            clr_n_q <= clr_n_d;
        end
    end

    // Idle slots inject zeros so a/b stay aligned and PEs accumulate nothing.
    assign a_in = accept ? bus.a_vec : '0;
    assign b_in = accept ? bus.b_vec : '0;

    for (genvar i = 0; i < N; i++) begin : g_lane
        systolic_feeder_lane #(.WIDTH(WIDTH), .DEPTH(i+1)) u_a (
            .clk(clk), .rst_n(rst_n), .d_i(a_in[i]), .q_o(west[i])
        );
        systolic_feeder_lane #(.WIDTH(WIDTH), .DEPTH(i+1)) u_b (
            .clk(clk), .rst_n(rst_n), .d_i(b_in[i]), .q_o(north[i])
        );
    end

    assign bus.west_out  = west;
    assign bus.north_out = north;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed and randomized bench for systolic_feeder (N=2) against a cycle-level
// transaction model of the feed/flush/done rules and a PE-array product check.
module tb_systolic_feeder;
    localparam int W = 16, N = 2, KW = 8, L = 2*N-1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    systolic_feeder_if #(.WIDTH(W), .N(N), .KW(KW)) bus ();
    systolic_feeder #(.WIDTH(W), .N(N), .KW(KW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0, errors = 0;

    // Model: mode 0 idle, 1 feeding, 2 flushing, 3 done; beats left and flush cycles left.
    int m_mode = 0, m_rem = 0, m_fl = 0;
    bit m_clr = 1'b0, m_init = 1'b0;
    logic [N-1:0][W-1:0] ha [N];
    logic [N-1:0][W-1:0] hb [N];
    int cyc = 0, last_acc = 0, done_cyc = -100, start_cyc = 0;
    int ws [64][N];
    int ns [64][N];
    int d1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit st, input int kl, input bit sv,
                        input logic [N*W-1:0] av, input logic [N*W-1:0] bv, input bit rn = 1'b1);
        bit acc;
        logic [N*W-1:0] ew, en;
        bus.start = st; bus.k_len = KW'(kl); bus.s_valid = sv;
        bus.a_vec = av; bus.b_vec = bv; rst_n = rn;
        if (m_init) chk("s_ready", 64'(bus.s_ready), 64'(m_mode == 1));
        acc = rn && (m_mode == 1) && sv;
        @(posedge clk);
        cyc++;
        m_clr = 1'b1;
        if (!rn) begin
            m_mode = 0; m_clr = 1'b0;
            for (int s = 0; s < N; s++) begin ha[s] = '0; hb[s] = '0; end
        end else begin
            for (int s = N-1; s > 0; s--) begin ha[s] = ha[s-1]; hb[s] = hb[s-1]; end
            ha[0] = acc ? av : '0;
            hb[0] = acc ? bv : '0;
            if (acc) last_acc = cyc;
            case (m_mode)
                0: if (st) begin
                    m_clr = 1'b0; start_cyc = cyc;
                    if (kl == 0) begin m_mode = 2; m_fl = L; end
                    else begin m_mode = 1; m_rem = kl; end
                end
                1: if (acc) begin
                    m_rem--;
                    if (m_rem == 0) begin m_mode = 2; m_fl = L; end
                end
                2: begin m_fl--; if (m_fl == 0) m_mode = 3; end
                default: m_mode = 0;
            endcase
        end
        m_init = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            ew[i*W +: W] = ha[i][i];
            en[i*W +: W] = hb[i][i];
        end
        chk("west_out", 64'(bus.west_out), 64'(ew));
        chk("north_out", 64'(bus.north_out), 64'(en));
        chk("busy", 64'(bus.busy), 64'(m_mode != 0));
        chk("done", 64'(bus.done), 64'(m_mode == 3));
        chk("clr_n", 64'(bus.clr_n), 64'(m_clr));
        for (int i = 0; i < N; i++) begin
            ws[cyc%64][i] = int'(bus.west_out[i*W +: W]);
            ns[cyc%64][i] = int'(bus.north_out[i*W +: W]);
        end
        if (bus.done === 1'b1) done_cyc = cyc;
    endtask

    task automatic idle_until_done(input int bound);
        for (int t = 0; t < bound && m_mode != 0 && bus.done !== 1'b1; t++)
            step(1'b0, 0, 1'b0, '0, '0);
    endtask

    // PE(i,j) multiplies west lane i delayed by j with north lane j delayed by i.
    task automatic pe_check(input string tag);
        int a_t [2][2];
        int b_t [2][2];
        int c, e, ti, tj;
        a_t = '{'{1, 2}, '{5, 6}};
        b_t = '{'{3, 4}, '{7, 8}};
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                c = 0; e = 0;
                for (int t = 1; t <= done_cyc - start_cyc; t++) begin
                    ti = t - j; tj = t - i;
                    if (ti >= 1 && tj >= 1)
                        c += ws[(start_cyc+ti)%64][i] * ns[(start_cyc+tj)%64][j];
                end
                for (int k = 0; k < 2; k++) e += a_t[k][i] * b_t[k][j];
                chk(tag, 64'(c), 64'(e));
            end
        end
    endtask

    initial begin
        step(1'b0, 0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 0, 1'b0, '0, '0, 1'b0);
        chk("rst_clr_n", 64'(bus.clr_n), 64'(0));

        // Back-to-back two-slice product.
        done_cyc = -100;
        step(1'b1, 2, 1'b0, '0, '0);
        chk("clr_lo", 64'(bus.clr_n), 64'(0));
        step(1'b0, 0, 1'b1, {16'd2, 16'd1}, {16'd4, 16'd3});
        chk("w0_first", 64'(bus.west_out[15:0]), 64'(1));
        step(1'b0, 0, 1'b1, {16'd6, 16'd5}, {16'd8, 16'd7});
        chk("w0_second", 64'(bus.west_out[15:0]), 64'(5));
        chk("w1_first", 64'(bus.west_out[31:16]), 64'(2));
        step(1'b0, 0, 1'b0, '0, '0);
        chk("w1_second", 64'(bus.west_out[31:16]), 64'(6));
        idle_until_done(10);
        chk("done_lat", 64'(done_cyc - last_acc), 64'(L));
        d1 = done_cyc - start_cyc;
        pe_check("pe_c");
        step(1'b0, 0, 1'b0, '0, '0);

        // Same product with a two-cycle stall; junk data on the stalled bus must not leak.
        done_cyc = -100;
        step(1'b1, 2, 1'b0, '0, '0);
        step(1'b0, 0, 1'b1, {16'd2, 16'd1}, {16'd4, 16'd3});
        step(1'b0, 0, 1'b0, {16'hdead, 16'hbeef}, {16'h1234, 16'h5678});
        chk("stall_w0", 64'(bus.west_out[15:0]), 64'(0));
        step(1'b0, 0, 1'b0, {16'hdead, 16'hbeef}, {16'h1234, 16'h5678});
        chk("stall_n0", 64'(bus.north_out[15:0]), 64'(0));
        step(1'b0, 0, 1'b1, {16'd6, 16'd5}, {16'd8, 16'd7});
        idle_until_done(12);
        chk("stall_delay", 64'(done_cyc - start_cyc), 64'(d1 + 2));
        pe_check("pe_c_stall");
        step(1'b0, 0, 1'b0, '0, '0);

        // Empty product goes straight to flush.
        done_cyc = -100;
        step(1'b1, 0, 1'b1, {16'd9, 16'd9}, {16'd9, 16'd9});
        idle_until_done(10);
        chk("k0_done", 64'(done_cyc - start_cyc), 64'(L));
        step(1'b0, 0, 1'b0, '0, '0);

        // start during FEED and FLUSH is ignored.
        done_cyc = -100;
        step(1'b1, 3, 1'b0, '0, '0);
        step(1'b1, 7, 1'b1, {16'd1, 16'd2}, {16'd3, 16'd4});
        step(1'b1, 1, 1'b1, {16'd5, 16'd6}, {16'd7, 16'd8});
        step(1'b0, 0, 1'b1, {16'd9, 16'd10}, {16'd11, 16'd12});
        step(1'b1, 5, 1'b1, {16'd13, 16'd14}, {16'd15, 16'd16});
        idle_until_done(10);
        chk("busy_start_done", 64'(done_cyc - last_acc), 64'(L));
        step(1'b0, 0, 1'b0, '0, '0);

        // Reset mid-feed aborts; the next short run completes.
        done_cyc = -100;
        step(1'b1, 4, 1'b0, '0, '0);
        step(1'b0, 0, 1'b1, {16'haaaa, 16'h5555}, {16'h0f0f, 16'hf0f0});
        step(1'b0, 0, 1'b1, {16'h1111, 16'h2222}, {16'h3333, 16'h4444}, 1'b0);
        chk("abort_west", 64'(bus.west_out), 64'(0));
        chk("abort_clr", 64'(bus.clr_n), 64'(0));
        for (int t = 0; t < 8; t++) step(1'b0, 0, 1'b1, '0, '0);
        chk("abort_no_done", 64'(done_cyc), 64'(-100));
        step(1'b1, 1, 1'b0, '0, '0);
        step(1'b0, 0, 1'b1, {16'd3, 16'd4}, {16'd5, 16'd6});
        idle_until_done(10);
        chk("after_abort_done", 64'(done_cyc - last_acc), 64'(L));
        step(1'b0, 0, 1'b0, '0, '0);

        // Randomized runs with stalls, ignored starts and occasional resets.
        for (int r = 0; r < 20; r++) begin
            step(1'b1, int'($urandom_range(0, 5)), 1'b0, '0, '0);
            for (int t = 0; t < 60 && m_mode != 0; t++)
                step(($urandom % 4) == 0, int'($urandom_range(0, 9)), ($urandom % 2) == 1,
                     N*W'($urandom), N*W'($urandom), ($urandom % 40) != 0);
            chk("rand_idle", 64'(m_mode), 64'(0));
            step(1'b0, 0, 1'b0, '0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
